// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: M0 (read-only fetch) and M1 (load/store)
// share one downstream port, one transaction at a time, round-robin between masters.
module axi4_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int RESP_WIDTH = 2
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iM0_ar_valid,
    output logic                  oM0_ar_ready,
    input  logic [ADDR_WIDTH-1:0] iM0_ar_addr,
    output logic                  oM0_r_valid,
    input  logic                  iM0_r_ready,
    output logic [DATA_WIDTH-1:0] oM0_r_data,
    output logic [RESP_WIDTH-1:0] oM0_r_resp,
    input  logic                  iM1_ar_valid,
    output logic                  oM1_ar_ready,
    input  logic [ADDR_WIDTH-1:0] iM1_ar_addr,
    output logic                  oM1_r_valid,
    input  logic                  iM1_r_ready,
    output logic [DATA_WIDTH-1:0] oM1_r_data,
    output logic [RESP_WIDTH-1:0] oM1_r_resp,
    input  logic                  iM1_aw_valid,
    output logic                  oM1_aw_ready,
    input  logic [ADDR_WIDTH-1:0] iM1_aw_addr,
    input  logic                  iM1_w_valid,
    output logic                  oM1_w_ready,
    input  logic [DATA_WIDTH-1:0] iM1_w_data,
    input  logic [MASK_WIDTH-1:0] iM1_w_strb,
    output logic                  oM1_b_valid,
    input  logic                  iM1_b_ready,
    output logic [RESP_WIDTH-1:0] oM1_b_resp,
    output logic                  oS_ar_valid,
    input  logic                  iS_ar_ready,
    output logic [ADDR_WIDTH-1:0] oS_ar_addr,
    input  logic                  iS_r_valid,
    output logic                  oS_r_ready,
    input  logic [DATA_WIDTH-1:0] iS_r_data,
    input  logic [RESP_WIDTH-1:0] iS_r_resp,
    output logic                  oS_aw_valid,
    input  logic                  iS_aw_ready,
    output logic [ADDR_WIDTH-1:0] oS_aw_addr,
    output logic                  oS_w_valid,
    input  logic                  iS_w_ready,
    output logic [DATA_WIDTH-1:0] oS_w_data,
    output logic [MASK_WIDTH-1:0] oS_w_strb,
    input  logic                  iS_b_valid,
    output logic                  oS_b_ready,
    input  logic [RESP_WIDTH-1:0] iS_b_resp,
    output logic [1:0]            oGrant
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_M0_RD      = 3'd1;
    localparam logic [2:0] ST_M1_RD      = 3'd2;
    localparam logic [2:0] ST_M1_WR      = 3'd3;
    localparam logic [2:0] ST_M1_WR_RESP = 3'd4;

    logic [2:0] state_r, state_next_s;
    logic       last_m1_r, last_m1_next_s;
    logic       ar_done_r, ar_done_next_s;
    logic       aw_done_r, aw_done_next_s;
    logic       w_done_r, w_done_next_s;
    logic [1:0] grant_r, grant_next_s;
    logic       req_m0_s, req_m1_s;
    logic       s_ar_hs_s, s_r_hs_s, s_aw_hs_s, s_w_hs_s, s_b_hs_s;

    assign oGrant    = grant_r;
    assign req_m0_s  = iM0_ar_valid;
    assign req_m1_s  = iM1_aw_valid | iM1_ar_valid;
    assign s_ar_hs_s = oS_ar_valid & iS_ar_ready;
    assign s_r_hs_s  = iS_r_valid & oS_r_ready;
    assign s_aw_hs_s = oS_aw_valid & iS_aw_ready;
    assign s_w_hs_s  = oS_w_valid & iS_w_ready;
    assign s_b_hs_s  = iS_b_valid & oS_b_ready;

    // Channel routing: only the granted master's channels are connected, everything else idles at zero.
    always_comb begin
        oS_ar_valid  = 1'b0;  oS_ar_addr  = '0;  oS_r_ready   = 1'b0;
        oS_aw_valid  = 1'b0;  oS_aw_addr  = '0;
        oS_w_valid   = 1'b0;  oS_w_data   = '0;  oS_w_strb    = '0;  oS_b_ready = 1'b0;
        oM0_ar_ready = 1'b0;  oM0_r_valid = 1'b0; oM0_r_data  = '0;  oM0_r_resp = '0;
        oM1_ar_ready = 1'b0;  oM1_r_valid = 1'b0; oM1_r_data  = '0;  oM1_r_resp = '0;
        oM1_aw_ready = 1'b0;  oM1_w_ready = 1'b0; oM1_b_valid = 1'b0; oM1_b_resp = '0;
        case (state_r)
            ST_M0_RD: begin
                oS_ar_valid  = iM0_ar_valid & ~ar_done_r;
                oS_ar_addr   = iM0_ar_addr;
                oM0_ar_ready = iS_ar_ready & ~ar_done_r;
                oM0_r_valid  = iS_r_valid;
                oM0_r_data   = iS_r_data;
                oM0_r_resp   = iS_r_resp;
                oS_r_ready   = iM0_r_ready;
            end
            ST_M1_RD: begin
                oS_ar_valid  = iM1_ar_valid & ~ar_done_r;
                oS_ar_addr   = iM1_ar_addr;
                oM1_ar_ready = iS_ar_ready & ~ar_done_r;
                oM1_r_valid  = iS_r_valid;
                oM1_r_data   = iS_r_data;
                oM1_r_resp   = iS_r_resp;
                oS_r_ready   = iM1_r_ready;
            end
            ST_M1_WR: begin
                oS_aw_valid  = iM1_aw_valid & ~aw_done_r;
                oS_aw_addr   = iM1_aw_addr;
                oM1_aw_ready = iS_aw_ready & ~aw_done_r;
                oS_w_valid   = iM1_w_valid & ~w_done_r;
                oS_w_data    = iM1_w_data;
                oS_w_strb    = iM1_w_strb;
                oM1_w_ready  = iS_w_ready & ~w_done_r;
            end
            ST_M1_WR_RESP: begin
                oM1_b_valid  = iS_b_valid;
                oM1_b_resp   = iS_b_resp;
                oS_b_ready   = iM1_b_ready;
            end
            default: begin
                oS_ar_valid  = 1'b0;
            end
        endcase
    end

    // Arbitration, phase tracking and grant encoding for the next cycle.
    always_comb begin
        state_next_s   = state_r;
        last_m1_next_s = last_m1_r;
        ar_done_next_s = ar_done_r;
        aw_done_next_s = aw_done_r;
        w_done_next_s  = w_done_r;
        case (state_r)
            ST_IDLE: begin
                if (req_m1_s && (!req_m0_s || !last_m1_r)) begin
                    last_m1_next_s = 1'b1;
                    state_next_s   = iM1_aw_valid ? ST_M1_WR : ST_M1_RD;
                end else if (req_m0_s) begin
                    last_m1_next_s = 1'b0;
                    state_next_s   = ST_M0_RD;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_M0_RD, ST_M1_RD: begin
                if (s_r_hs_s) begin
                    state_next_s   = ST_IDLE;
                    ar_done_next_s = 1'b0;
                end else begin
                    ar_done_next_s = ar_done_r | s_ar_hs_s;
                end
            end
            ST_M1_WR: begin
                // Both halves may complete in the same cycle; move on as soon as neither is outstanding.
                if ((aw_done_r | s_aw_hs_s) && (w_done_r | s_w_hs_s)) begin
                    state_next_s   = ST_M1_WR_RESP;
                    aw_done_next_s = 1'b0;
                    w_done_next_s  = 1'b0;
                end else begin
                    aw_done_next_s = aw_done_r | s_aw_hs_s;
                    w_done_next_s  = w_done_r | s_w_hs_s;
                end
            end
            ST_M1_WR_RESP: begin
                if (s_b_hs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_M1_WR_RESP;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                ar_done_next_s = 1'b0;
                aw_done_next_s = 1'b0;
                w_done_next_s  = 1'b0;
            end
        endcase
        case (state_next_s)
            ST_M0_RD:                         grant_next_s = 2'b01;
            ST_M1_RD, ST_M1_WR, ST_M1_WR_RESP: grant_next_s = 2'b10;
            default:                          grant_next_s = 2'b00;
        endcase
    end

    // State, pointer, done flags and grant register with synchronous reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r   <= ST_IDLE;
            last_m1_r <= 1'b1;
            ar_done_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            grant_r   <= 2'b00;
        end else begin
            state_r   <= state_next_s;
            last_m1_r <= last_m1_next_s;
            ar_done_r <= ar_done_next_s;
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
            grant_r   <= grant_next_s;
        end
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Self-checking bench for axi4_lite_arbiter: bench-side masters, a slave with a
// transaction-level memory model, and a round-robin grant predictor.
module tb_axi4_lite_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
    logic [31:0] m0_ar_addr, m0_r_data;
    logic [1:0]  m0_r_resp;
    logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
    logic [31:0] m1_ar_addr, m1_r_data;
    logic [1:0]  m1_r_resp;
    logic m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready, m1_b_valid, m1_b_ready;
    logic [31:0] m1_aw_addr, m1_w_data;
    logic [3:0]  m1_w_strb;
    logic [1:0]  m1_b_resp;
    logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [31:0] s_ar_addr, s_r_data;
    logic [1:0]  s_r_resp;
    logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [31:0] s_aw_addr, s_w_data;
    logic [3:0]  s_w_strb;
    logic [1:0]  s_b_resp;
    logic [1:0]  grant;

    axi4_lite_arbiter dut (
        .iClock(clk), .iReset(rst),
        .iM0_ar_valid(m0_ar_valid), .oM0_ar_ready(m0_ar_ready), .iM0_ar_addr(m0_ar_addr),
        .oM0_r_valid(m0_r_valid), .iM0_r_ready(m0_r_ready), .oM0_r_data(m0_r_data), .oM0_r_resp(m0_r_resp),
        .iM1_ar_valid(m1_ar_valid), .oM1_ar_ready(m1_ar_ready), .iM1_ar_addr(m1_ar_addr),
        .oM1_r_valid(m1_r_valid), .iM1_r_ready(m1_r_ready), .oM1_r_data(m1_r_data), .oM1_r_resp(m1_r_resp),
        .iM1_aw_valid(m1_aw_valid), .oM1_aw_ready(m1_aw_ready), .iM1_aw_addr(m1_aw_addr),
        .iM1_w_valid(m1_w_valid), .oM1_w_ready(m1_w_ready), .iM1_w_data(m1_w_data), .iM1_w_strb(m1_w_strb),
        .oM1_b_valid(m1_b_valid), .iM1_b_ready(m1_b_ready), .oM1_b_resp(m1_b_resp),
        .oS_ar_valid(s_ar_valid), .iS_ar_ready(s_ar_ready), .oS_ar_addr(s_ar_addr),
        .iS_r_valid(s_r_valid), .oS_r_ready(s_r_ready), .iS_r_data(s_r_data), .iS_r_resp(s_r_resp),
        .oS_aw_valid(s_aw_valid), .iS_aw_ready(s_aw_ready), .oS_aw_addr(s_aw_addr),
        .oS_w_valid(s_w_valid), .iS_w_ready(s_w_ready), .oS_w_data(s_w_data), .oS_w_strb(s_w_strb),
        .iS_b_valid(s_b_valid), .oS_b_ready(s_b_ready), .iS_b_resp(s_b_resp),
        .oGrant(grant)
    );

    int cyc, n_checks, n_pass;
    // bench masters
    bit m0_pend, m0_ar_done, m1r_pend, m1r_ar_done, m1w_pend, m1w_aw_done, m1w_w_done;
    logic [31:0] m0_addr, m1r_addr, m1w_addr, m1w_data;
    logic [3:0]  m1w_strb;
    bit rnd_ready, rnd_dly;
    // bench slave
    int s_ar_dly, s_aw_dly, s_w_dly, s_ar_cnt, s_aw_cnt, s_w_cnt;
    bit s_rd_pend, s_aw_got, s_w_got, s_b_pend;
    logic [31:0] s_rd_addr, s_wr_addr, s_wr_data;
    logic [3:0]  s_wr_strb;
    // reference model and observation records
    bit mdl_busy, mdl_wr, mdl_last_m1;
    logic [1:0] exp_grant, prev_grant;
    int dut_glog[$];
    int done_log[$];
    int t_req, t_dut_grant, t_dut_idle, t_s_ar, t_s_aw, t_s_w, t_r0;
    logic [31:0] last_m0_data;
    logic [1:0]  last_m0_resp, last_m1r_resp, last_b_resp;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a ^ 32'h8000_0000) * 32'h9E37_79B9 + 32'h0000_0413;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        case (a[7:4])
            4'hE:    return 2'b10;
            4'hF:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic clear_tb();
        m0_pend = 1'b0; m0_ar_done = 1'b0; m1r_pend = 1'b0; m1r_ar_done = 1'b0;
        m1w_pend = 1'b0; m1w_aw_done = 1'b0; m1w_w_done = 1'b0;
        m0_addr = 32'h0; m1r_addr = 32'h0; m1w_addr = 32'h0; m1w_data = 32'h0; m1w_strb = 4'h0;
        rnd_ready = 1'b0; rnd_dly = 1'b0;
        s_ar_dly = 0; s_aw_dly = 0; s_w_dly = 0; s_ar_cnt = 0; s_aw_cnt = 0; s_w_cnt = 0;
        s_rd_pend = 1'b0; s_aw_got = 1'b0; s_w_got = 1'b0; s_b_pend = 1'b0;
        s_rd_addr = 32'h0; s_wr_addr = 32'h0; s_wr_data = 32'h0; s_wr_strb = 4'h0;
        mdl_busy = 1'b0; mdl_wr = 1'b0; mdl_last_m1 = 1'b1;
        exp_grant = 2'b00; prev_grant = 2'b00;
    endtask

    task automatic drive();
        m0_ar_valid = m0_pend && !m0_ar_done;
        m0_ar_addr  = m0_pend ? m0_addr : 32'h0;
        m0_r_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        m1_ar_valid = m1r_pend && !m1r_ar_done;
        m1_ar_addr  = m1r_pend ? m1r_addr : 32'h0;
        m1_r_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        m1_aw_valid = m1w_pend && !m1w_aw_done;
        m1_aw_addr  = m1w_pend ? m1w_addr : 32'h0;
        m1_w_valid  = m1w_pend && !m1w_w_done;
        m1_w_data   = m1w_pend ? m1w_data : 32'h0;
        m1_w_strb   = m1w_pend ? m1w_strb : 4'h0;
        m1_b_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        s_ar_ready  = (s_ar_cnt >= s_ar_dly);
        s_aw_ready  = (s_aw_cnt >= s_aw_dly);
        s_w_ready   = (s_w_cnt >= s_w_dly);
        s_r_valid   = s_rd_pend;
        s_r_data    = s_rd_pend ? mem_data(s_rd_addr) : 32'h0;
        s_r_resp    = s_rd_pend ? resp_of(s_rd_addr) : 2'b00;
        s_b_valid   = s_b_pend;
        s_b_resp    = s_b_pend ? resp_of(s_wr_addr) : 2'b00;
    endtask

    task automatic sample();
        bit pick_m1, fin;
        check_eq("grant", 64'(grant), 64'(exp_grant));
        if (exp_grant != 2'b01) check_eq("m0_isolated", 64'({m0_ar_ready, m0_r_valid}), 64'h0);
        if (exp_grant != 2'b10)
            check_eq("m1_isolated", 64'({m1_ar_ready, m1_r_valid, m1_aw_ready, m1_w_ready, m1_b_valid}), 64'h0);
        if (exp_grant == 2'b00)
            check_eq("idle_downstream", 64'({s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}), 64'h0);
        if (grant != 2'b00 && prev_grant == 2'b00) begin t_dut_grant = cyc; dut_glog.push_back(int'(grant)); end
        if (grant == 2'b00 && prev_grant != 2'b00) t_dut_idle = cyc;
        prev_grant = grant;
        // slave side
        if (s_r_valid && s_r_ready) s_rd_pend = 1'b0;
        if (s_b_valid && s_b_ready) s_b_pend = 1'b0;
        if (s_ar_valid && s_ar_ready) begin
            s_rd_pend = 1'b1; s_rd_addr = s_ar_addr; s_ar_cnt = 0; t_s_ar = cyc;
            if (rnd_dly) s_ar_dly = $urandom_range(0, 3);
        end else if (s_ar_valid) s_ar_cnt++;
        if (s_aw_valid && s_aw_ready) begin
            s_aw_got = 1'b1; s_wr_addr = s_aw_addr; s_aw_cnt = 0; t_s_aw = cyc;
            if (rnd_dly) s_aw_dly = $urandom_range(0, 3);
        end else if (s_aw_valid) s_aw_cnt++;
        if (s_w_valid && s_w_ready) begin
            s_w_got = 1'b1; s_wr_data = s_w_data; s_wr_strb = s_w_strb; s_w_cnt = 0; t_s_w = cyc;
            if (rnd_dly) s_w_dly = $urandom_range(0, 3);
        end else if (s_w_valid) s_w_cnt++;
        if (s_aw_got && s_w_got) begin
            check_eq("s_wr_addr", 64'(s_wr_addr), 64'(m1w_addr));
            check_eq("s_wr_data", 64'({s_wr_strb, s_wr_data}), 64'({m1w_strb, m1w_data}));
            s_aw_got = 1'b0; s_w_got = 1'b0; s_b_pend = 1'b1;
        end
        // master side
        if (m0_ar_valid && m0_ar_ready) m0_ar_done = 1'b1;
        if (m0_r_valid && m0_r_ready) begin
            check_eq("m0_r_owner", 64'(m0_pend && m0_ar_done), 64'h1);
            check_eq("m0_r_data", 64'(m0_r_data), 64'(mem_data(m0_addr)));
            check_eq("m0_r_resp", 64'(m0_r_resp), 64'(resp_of(m0_addr)));
            last_m0_data = m0_r_data; last_m0_resp = m0_r_resp; t_r0 = cyc;
            done_log.push_back(0); m0_pend = 1'b0; m0_ar_done = 1'b0;
        end
        if (m1_ar_valid && m1_ar_ready) m1r_ar_done = 1'b1;
        if (m1_r_valid && m1_r_ready) begin
            check_eq("m1_r_owner", 64'(m1r_pend && m1r_ar_done), 64'h1);
            check_eq("m1_r_data", 64'(m1_r_data), 64'(mem_data(m1r_addr)));
            check_eq("m1_r_resp", 64'(m1_r_resp), 64'(resp_of(m1r_addr)));
            last_m1r_resp = m1_r_resp;
            done_log.push_back(1); m1r_pend = 1'b0; m1r_ar_done = 1'b0;
        end
        if (m1_aw_valid && m1_aw_ready) m1w_aw_done = 1'b1;
        if (m1_w_valid && m1_w_ready) m1w_w_done = 1'b1;
        if (m1_b_valid && m1_b_ready) begin
            check_eq("m1_b_owner", 64'(m1w_pend && m1w_aw_done && m1w_w_done), 64'h1);
            check_eq("m1_b_resp", 64'(m1_b_resp), 64'(resp_of(m1w_addr)));
            last_b_resp = m1_b_resp;
            done_log.push_back(2); m1w_pend = 1'b0; m1w_aw_done = 1'b0; m1w_w_done = 1'b0;
        end
        // grant predictor: one transaction at a time, round-robin on simultaneous requests
        if (mdl_busy) begin
            fin = mdl_wr ? (s_b_valid && m1_b_ready)
                         : (s_r_valid && (exp_grant == 2'b01 ? m0_r_ready : m1_r_ready));
            if (fin) begin mdl_busy = 1'b0; exp_grant = 2'b00; end
        end else if (m0_ar_valid || m1_aw_valid || m1_ar_valid) begin
            pick_m1     = (m1_aw_valid || m1_ar_valid) && (!m0_ar_valid || !mdl_last_m1);
            mdl_last_m1 = pick_m1;
            mdl_wr      = pick_m1 && m1_aw_valid;
            exp_grant   = pick_m1 ? 2'b10 : 2'b01;
            mdl_busy    = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk); cyc++;
        #1 drive();
        #4 sample();
    endtask

    function automatic bit busy_any();
        return m0_pend || m1r_pend || m1w_pend || s_rd_pend || s_b_pend || mdl_busy;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while (busy_any() && n < budget) begin step(); n++; end
        check_eq({tag, "_drained"}, 64'(busy_any()), 64'h0);
        step();
    endtask

    task automatic reset_dut();
        @(posedge clk); cyc++;
        #1 rst = 1'b1; clear_tb(); drive();
        @(posedge clk); cyc++;
        #1 rst = 1'b0; drive();
        #4;
        check_eq("rst_ctrl", 64'({grant, m0_ar_ready, m0_r_valid, m1_ar_ready, m1_r_valid, m1_aw_ready,
                                  m1_w_ready, m1_b_valid, s_ar_valid, s_r_ready, s_aw_valid, s_w_valid,
                                  s_b_ready}), 64'h0);
        check_eq("rst_data", 64'(|{m0_r_data, m0_r_resp, m1_r_data, m1_r_resp, m1_b_resp,
                                   s_ar_addr, s_aw_addr, s_w_data, s_w_strb}), 64'h0);
        sample();
    endtask

    task automatic issue_m0(input logic [31:0] a);
        m0_pend = 1'b1; m0_ar_done = 1'b0; m0_addr = a;
    endtask
    task automatic issue_m1r(input logic [31:0] a);
        m1r_pend = 1'b1; m1r_ar_done = 1'b0; m1r_addr = a;
    endtask
    task automatic issue_m1w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m1w_pend = 1'b1; m1w_aw_done = 1'b0; m1w_w_done = 1'b0; m1w_addr = a; m1w_data = d; m1w_strb = s;
    endtask

    function automatic logic [63:0] pack_log(input int q[$]);
        logic [63:0] v = 64'h0;
        foreach (q[i]) v = (v << 4) | 64'(q[i]);
        return v;
    endfunction

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0; rst = 1'b1;
        clear_tb(); drive();
        reset_dut();

        // zero-wait M0 read: grant N+1, data N+2, idle N+3
        issue_m0(32'h8000_0000); t_req = cyc + 1;
        run_until_idle("t1", 20);
        check_eq("t1_grant_lat", 64'(t_dut_grant - t_req), 64'd1);
        check_eq("t1_s_ar_lat", 64'(t_s_ar - t_req), 64'd1);
        check_eq("t1_r_lat", 64'(t_r0 - t_req), 64'd2);
        check_eq("t1_idle_lat", 64'(t_dut_idle - t_req), 64'd3);
        check_eq("t1_data", 64'({last_m0_resp, last_m0_data}), 64'h0_0000_0413);

        // M1 write+read with M0 also requesting, M0 granted last: write, M0, then M1 read
        done_log.delete();
        issue_m1w(32'h8000_2000, 32'h1234_5678, 4'h3);
        issue_m1r(32'h8000_3000);
        issue_m0(32'h8000_4000);
        run_until_idle("t4", 60);
        check_eq("t4_order", pack_log(done_log), 64'h201);

        // SLVERR passes through, following M0 read unaffected
        issue_m1r(32'h0000_20E0);
        run_until_idle("t5a", 20);
        check_eq("t5_slverr", 64'(last_m1r_resp), 64'h2);
        issue_m0(32'h0000_0100);
        run_until_idle("t5b", 20);
        check_eq("t5_m0_after", 64'({last_m0_resp, last_m0_data}), 64'({2'b00, mem_data(32'h0000_0100)}));

        // write with AW delayed 3 and W delayed 1
        s_aw_dly = 3; s_w_dly = 1;
        issue_m1w(32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
        run_until_idle("t3", 40);
        check_eq("t3_w_first", 64'(t_s_w - t_dut_grant), 64'd1);
        check_eq("t3_aw_after", 64'(t_s_aw - t_dut_grant), 64'd3);
        check_eq("t3_bresp", 64'(last_b_resp), 64'h0);

        // reset while AW done and W pending
        s_aw_dly = 0; s_w_dly = 20;
        issue_m1w(32'h8000_5000, 32'hCAFE_F00D, 4'hF);
        for (int i = 0; i < 20 && !m1w_aw_done; i++) step();
        check_eq("t6_mid_write", 64'({m1w_aw_done, m1w_w_done}), 64'h2);
        reset_dut();
        issue_m0(32'h8000_0040);
        run_until_idle("t6", 20);
        check_eq("t6_m0_after", 64'(last_m0_data), 64'(mem_data(32'h8000_0040)));

        // strict alternation of three rounds after reset
        begin
            int m0_left = 2, m1_left = 2, n = 0;
            reset_dut();
            dut_glog.delete();
            issue_m0(32'h8000_0100); issue_m1r(32'h8000_0200);
            while ((m0_left > 0 || m1_left > 0 || busy_any()) && n < 200) begin
                step(); n++;
                if (!m0_pend && m0_left > 0) begin issue_m0($urandom); m0_left--; end
                if (!m1r_pend && m1_left > 0) begin issue_m1r($urandom); m1_left--; end
            end
            check_eq("t2_drained", 64'(busy_any()), 64'h0);
            check_eq("t2_order", pack_log(dut_glog), 64'h12_1212);
        end

        // random traffic with random backpressure and slave latency
        done_log.delete();
        rnd_ready = 1'b1; rnd_dly = 1'b1;
        for (int i = 0; i < 800; i++) begin
            step();
            if (!m0_pend && $urandom_range(0, 3) == 0) issue_m0($urandom);
            if (!m1r_pend && $urandom_range(0, 3) == 0) issue_m1r($urandom);
            if (!m1w_pend && $urandom_range(0, 3) == 0)
                issue_m1w($urandom, $urandom, 4'($urandom_range(1, 15)));
        end
        run_until_idle("t7", 300);
        check_eq("t7_progress", 64'(done_log.size() >= 40), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
